// File: rtl/s4ga_cfg_streamer_pkg.sv
// Shared sizing helpers and FSM state type for the s4ga configuration path.
// Both the streamer and the LUT engine derive their segment counts from these.
package s4ga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2
  } state_e;

  // A LUT index needs clog2(n) bits, split into si_w-bit segments.
  function automatic int idx_segs(input int n, input int si_w);
    return ($clog2(n) + si_w - 1) / si_w;
  endfunction

  function automatic int mask_segs(input int k, input int si_w);
    return ((1 << k) + si_w - 1) / si_w;
  endfunction

  function automatic int frame_segs(input int n, input int k, input int si_w);
    return k * idx_segs(n, si_w) + mask_segs(k, si_w);
  endfunction

  function automatic int total_segs(input int n, input int k, input int si_w);
    return n * frame_segs(n, k, si_w);
  endfunction

endpackage

// File: rtl/s4ga_cfg_streamer_if.sv
// Load-beat handshake between host/scan-in logic and the configuration streamer.
// With S4GA_CFG_PARITY_EN defined, each beat also carries an even-parity bit.
interface s4ga_cfg_streamer_if #(
  parameter int SI_W = 4
);
  logic            ld_valid;
  logic            ld_ready;
  logic [SI_W-1:0] ld_data;
`ifdef S4GA_CFG_PARITY_EN
  logic            ld_par;

  modport master (output ld_valid, output ld_data, output ld_par, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_par, output ld_ready);
`else
  modport master (output ld_valid, output ld_data, input ld_ready);
  modport slave  (input ld_valid, input ld_data, output ld_ready);
`endif
endinterface

// File: rtl/s4ga_seg_ram.sv
// Single-port segment store: unreset memory array with a registered read port.
// The read register clears when re is low, so it doubles as the engine's si register.
module s4ga_seg_ram #(
  parameter int DEPTH  = 1602,
  parameter int DATA_W = 4,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/s4ga_cfg_streamer.sv
// Configuration streamer for the s4ga LUT engine: loads one image, then holds the
// engine in reset and streams the image cyclically. Optional macro: S4GA_CFG_PARITY_EN.
module s4ga_cfg_streamer
  import s4ga_pkg::*;
#(
  parameter int N    = 89,
  parameter int K    = 5,
  parameter int SI_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  s4ga_cfg_streamer_if.slave       ld,
  input  logic                     start,
  input  logic                     stop,
  output logic [SI_W-1:0]          eng_si,
  output logic                     eng_rst,
  output logic                     loaded,
  output logic                     running,
`ifdef S4GA_CFG_PARITY_EN
  output logic                     cfg_err,
`endif
  output logic                     frame_start
);

  localparam int TOTAL_SEGS = total_segs(N, K, SI_W);
  localparam int ADDR_W     = $clog2(TOTAL_SEGS);
  localparam int RST_CYC    = N + 2;
  localparam int CNT_W      = $clog2(RST_CYC);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_SEGS - 1);
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(RST_CYC - 1);

  state_e            state;
  state_e            state_nxt;
  logic [CNT_W-1:0]  rst_cnt;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic              wr_en;
  logic              rd_en;
  logic              start_ok;

  assign ld.ld_ready = (state == IDLE) && !rst;
  assign wr_en       = ld.ld_valid && ld.ld_ready;
  assign running     = (state == RUN);

`ifdef S4GA_CFG_PARITY_EN
  assign start_ok = loaded && !cfg_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else if (wr_en && (ld.ld_par != ^ld.ld_data)) begin
      cfg_err <= 1'b1;
    end
  end
`else
  assign start_ok = loaded;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // stop dominates start in every state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && start_ok && !stop) state_nxt = RESET;
      RESET: begin
        if (stop)              state_nxt = IDLE;
        else if (rst_cnt == '0) state_nxt = RUN;
      end
      RUN:     if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt <= CNT_INIT;
    end else if (state == IDLE) begin
      rst_cnt <= CNT_INIT;
    end else if (state == RESET && rst_cnt != '0) begin
      rst_cnt <= rst_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      loaded <= 1'b0;
    end else if (wr_en) begin
      if (wptr == LAST_ADDR) begin
        wptr   <= '0;
        loaded <= 1'b1;
      end else begin
        wptr <= wptr + ADDR_W'(1);
      end
    end
  end

  // Read address is 0 until RUN; the segment for cycle c+1 is fetched in cycle c.
  assign rd_addr  = (state == RUN) ? raddr : '0;
  assign rd_en    = (state_nxt == RUN);
  assign ram_addr = (state == IDLE) ? wptr : rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr <= '0;
    end else if (rd_en) begin
      raddr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);
    end else begin
      raddr <= '0;
    end
  end

  // Stage p1: RAM read register, engine reset and frame marker all update together.
  s4ga_seg_ram #(
    .DEPTH  (TOTAL_SEGS),
    .DATA_W (SI_W),
    .ADDR_W (ADDR_W)
  ) u_seg_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (ram_addr),
    .wdata (ld.ld_data),
    .rdata (eng_si)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_rst     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      eng_rst     <= !rd_en;
      frame_start <= rd_en && (rd_addr == '0);
    end
  end

endmodule

// File: tb/tb_s4ga_cfg_streamer.sv
// Directed bench for s4ga_cfg_streamer at N=5, K=2, SI_W=4 (15 segments, 7 reset cycles).
module tb_s4ga_cfg_streamer;

  localparam int TOTAL   = 15;
  localparam int RST_CYC = 7;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] eng_si;
  logic       eng_rst;
  logic       loaded;
  logic       running;
  logic       frame_start;
`ifdef S4GA_CFG_PARITY_EN
  logic       cfg_err;
`endif

  int errors = 0;
  int checks = 0;

  s4ga_cfg_streamer_if #(.SI_W(4)) ld_if ();

  s4ga_cfg_streamer #(.N(5), .K(2), .SI_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld          (ld_if),
    .start       (start),
    .stop        (stop),
    .eng_si      (eng_si),
    .eng_rst     (eng_rst),
    .loaded      (loaded),
    .running     (running),
`ifdef S4GA_CFG_PARITY_EN
    .cfg_err     (cfg_err),
`endif
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] pat(input int i);
    return 4'((i * 7 + 3) & 15);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic [3:0] d);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = d;
`ifdef S4GA_CFG_PARITY_EN
    ld_if.ld_par   = ^d;
`endif
    step();
    ld_if.ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (eng_rst !== 1'b1) begin errors++; $display("FAIL reset_eng_rst got=%b want=1", eng_rst); end
    checks++; if (eng_si !== 4'h0) begin errors++; $display("FAIL reset_eng_si got=%h want=0", eng_si); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b want=0", running); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got=%b want=0", frame_start); end
    checks++; if (ld_if.ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got=%b want=0", ld_if.ld_ready); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded got=%b want=0", loaded); end
    step();
    step();
    rst = 1'b0;
    step();
    checks++; if (ld_if.ld_ready !== 1'b1) begin errors++; $display("FAIL idle_ld_ready got=%b want=1", ld_if.ld_ready); end
    checks++; if (eng_rst !== 1'b1) begin errors++; $display("FAIL idle_eng_rst got=%b want=1", eng_rst); end
  endtask

  task automatic test_start_early();
    for (int i = 0; i < 10; i++) load_beat(4'(i));
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL early_running got=%b want=0", running); end
    checks++; if (ld_if.ld_ready !== 1'b1) begin errors++; $display("FAIL early_ld_ready got=%b want=1", ld_if.ld_ready); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL early_loaded got=%b want=0", loaded); end
    checks++; if (dut.wptr !== 4'd10) begin errors++; $display("FAIL early_wptr got=%0d want=10", dut.wptr); end
    for (int i = 0; i < RST_CYC + 2; i++) step();
    checks++; if (eng_rst !== 1'b1) begin errors++; $display("FAIL early_eng_rst got=%b want=1", eng_rst); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL early_running_late got=%b want=0", running); end
  endtask

  task automatic test_load();
    for (int i = 10; i < TOTAL - 1; i++) load_beat(4'(i));
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL load_before_last got=%b want=0", loaded); end
    load_beat(4'hE);
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL load_loaded got=%b want=1", loaded); end
    checks++; if (dut.wptr !== 4'd0) begin errors++; $display("FAIL load_wptr_wrap got=%0d want=0", dut.wptr); end
  endtask

  task automatic test_start();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= RST_CYC; c++) begin
      checks++; if (eng_rst !== 1'b1) begin errors++; $display("FAIL start_rst_c%0d got=%b want=1", c, eng_rst); end
      checks++; if (eng_si !== 4'h0) begin errors++; $display("FAIL start_si_c%0d got=%h want=0", c, eng_si); end
      checks++; if (ld_if.ld_ready !== 1'b0) begin errors++; $display("FAIL start_ready_c%0d got=%b want=0", c, ld_if.ld_ready); end
      step();
    end
    for (int k = 0; k <= TOTAL; k++) begin
      checks++; if (eng_rst !== 1'b0) begin errors++; $display("FAIL run_rst_k%0d got=%b want=0", k, eng_rst); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running_k%0d got=%b want=1", k, running); end
      checks++; if (eng_si !== 4'(k % TOTAL)) begin errors++; $display("FAIL run_si_k%0d got=%h want=%h", k, eng_si, 4'(k % TOTAL)); end
      checks++; if (frame_start !== ((k % TOTAL) == 0)) begin errors++; $display("FAIL run_fs_k%0d got=%b want=%b", k, frame_start, (k % TOTAL) == 0); end
      step();
    end
  endtask

  task automatic test_collision();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL coll_running got=%b want=0", running); end
    checks++; if (eng_rst !== 1'b1) begin errors++; $display("FAIL coll_eng_rst got=%b want=1", eng_rst); end
    checks++; if (eng_si !== 4'h0) begin errors++; $display("FAIL coll_eng_si got=%h want=0", eng_si); end
    checks++; if (ld_if.ld_ready !== 1'b1) begin errors++; $display("FAIL coll_ld_ready got=%b want=1", ld_if.ld_ready); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL coll_fs got=%b want=0", frame_start); end
    for (int i = 0; i < RST_CYC + 2; i++) step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL coll_stays_idle got=%b want=0", running); end
  endtask

  task automatic test_stop_in_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (ld_if.ld_ready !== 1'b1) begin errors++; $display("FAIL stopr_ld_ready got=%b want=1", ld_if.ld_ready); end
    for (int i = 0; i < RST_CYC + 2; i++) step();
    checks++; if (eng_rst !== 1'b1) begin errors++; $display("FAIL stopr_eng_rst got=%b want=1", eng_rst); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stopr_running got=%b want=0", running); end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < RST_CYC + 5; i++) step();
    checks++; if (eng_si !== 4'h5) begin errors++; $display("FAIL arst_pre_si got=%h want=5", eng_si); end
    #3 rst = 1'b1;
    #1;
    checks++; if (eng_si !== 4'h0) begin errors++; $display("FAIL arst_si got=%h want=0", eng_si); end
    checks++; if (eng_rst !== 1'b1) begin errors++; $display("FAIL arst_eng_rst got=%b want=1", eng_rst); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL arst_running got=%b want=0", running); end
    checks++; if (ld_if.ld_ready !== 1'b0) begin errors++; $display("FAIL arst_ld_ready got=%b want=0", ld_if.ld_ready); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL arst_loaded got=%b want=0", loaded); end
    step();
    #2 rst = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < RST_CYC + 2; i++) step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL arst_start_ignored got=%b want=0", running); end
    // last beat and start together: start sees the pre-beat loaded=0
    for (int i = 0; i < TOTAL - 1; i++) load_beat(pat(i));
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = pat(TOTAL - 1);
`ifdef S4GA_CFG_PARITY_EN
    ld_if.ld_par   = ^pat(TOTAL - 1);
`endif
    start = 1'b1;
    step();
    ld_if.ld_valid = 1'b0;
    start = 1'b0;
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL reload_loaded got=%b want=1", loaded); end
    for (int i = 0; i < RST_CYC + 2; i++) step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL beat_start_same_cycle got=%b want=0", running); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < RST_CYC; i++) step();
    for (int k = 0; k < TOTAL; k++) begin
      checks++; if (eng_si !== pat(k)) begin errors++; $display("FAIL reload_si_k%0d got=%h want=%h", k, eng_si, pat(k)); end
      checks++; if (frame_start !== (k == 0)) begin errors++; $display("FAIL reload_fs_k%0d got=%b want=%b", k, frame_start, k == 0); end
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

`ifdef S4GA_CFG_PARITY_EN
  task automatic test_parity();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL par_clear got=%b want=0", cfg_err); end
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = 4'h3;
    ld_if.ld_par   = 1'b1;
    step();
    ld_if.ld_valid = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL par_err got=%b want=1", cfg_err); end
    for (int i = 1; i < TOTAL; i++) load_beat(4'(i));
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL par_loaded got=%b want=1", loaded); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < RST_CYC + 2; i++) step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL par_start_ignored got=%b want=0", running); end
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL par_sticky got=%b want=1", cfg_err); end
  endtask
`endif

  initial begin
    rst            = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = 4'h0;
`ifdef S4GA_CFG_PARITY_EN
    ld_if.ld_par   = 1'b0;
`endif
    test_reset();
    test_start_early();
    test_load();
    test_start();
    test_collision();
    test_stop_in_reset();
    test_async_reset();
`ifdef S4GA_CFG_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s4ga_cfg_streamer.md
# s4ga_cfg_streamer

Upstream feeder for the s4ga LUT engine. Holds one full configuration image (N LUT frames) in on-chip segment RAM, loaded over a valid/ready beat interface. On command it drives the engine's sync reset for more than N cycles, then streams the image cyclically, one SI_W-bit segment per clock, on the engine's `si` input. Sits between the host/scan-in logic and the engine's `io_in` bundle.

## Interface
- `N`, default 89: LUT count; must match the engine.
- `K`, default 5: LUT inputs; must match the engine.
- `SI_W`, default 4: segment width; must match the engine.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ld_valid`  in  1  load beat valid.
- `ld_ready`  out  1  load beat accepted when `ld_valid & ld_ready`.
- `ld_data`  in  SI_W  one configuration segment.
- `start`  in  1  single-cycle pulse: begin reset and run sequence.
- `stop`  in  1  single-cycle pulse: return to IDLE.
- `eng_si`  out  SI_W  segment to the engine, registered.
- `eng_rst`  out  1  engine sync reset, registered.
- `loaded`  out  1  a complete image has been written.
- `running`  out  1  state is RUN.
- `frame_start`  out  1  high in the cycle when `eng_si` carries segment 0 of LUT 0.

## Operation
- Derived constants:
  - N_W = clog2(N); MASK_W = 2**K.
  - IDX_SEGS = ceil(N_W/SI_W); MASK_SEGS = ceil(MASK_W/SI_W).
  - FRAME_SEGS = K*IDX_SEGS + MASK_SEGS; TOTAL_SEGS = N*FRAME_SEGS.
  - ADDR_W = clog2(TOTAL_SEGS); RST_CYC = N+2.
  - Defaults give 18 segments per frame, 1602 total, ADDR_W=11.
- Image order is LUT 0 to LUT N-1. Within a frame: index 0 to index K-1, then the mask. Each field is sent most-significant segment first. The streamer does not interpret content.
- FSM states: IDLE, RESET, RUN.
- IDLE:
  - `ld_ready`=1 and `eng_rst`=1.
  - Each accepted beat is written at `wptr`, then `wptr` increments. At TOTAL_SEGS-1 it wraps to 0 and sets `loaded`.
  - A partial reload leaves `loaded` unchanged; `loaded` is sticky until `rst`.
- IDLE to RESET: `start` while `loaded`=1. `start` with `loaded`=0 is ignored.
  - A beat and `start` in the same cycle: the beat is written, and `start` is evaluated against the pre-beat `loaded`.
- RESET:
  - `ld_ready`=0, `eng_rst`=1, `eng_si`=0.
  - A down-counter runs RST_CYC cycles, and the read address is forced to 0.
  - When the counter expires, go to RUN.
- RUN:
  - `eng_rst`=0. `eng_si` shows segment `raddr` each cycle.
  - `raddr` increments and wraps TOTAL_SEGS-1 to 0 with no gap cycle.
  - `frame_start`=1 exactly when the displayed segment index is 0.
- `stop` in RESET or RUN goes to IDLE. `stop` and `start` in the same cycle: `stop` wins. `start` outside IDLE is ignored.
- Asynchronous `rst` forces:
  - state IDLE, `wptr`=0, `loaded`=0;
  - `eng_rst`=1, `eng_si`=0, `frame_start`=0, `running`=0, `ld_ready`=0 while `rst` is asserted.
  - RAM contents are not cleared.

## Timing
- RAM read is synchronous, 1 cycle. The address for segment 0 is issued in the last RESET cycle.
- `eng_si` and `eng_rst` are registered together, so the engine sees the first cycle with `eng_rst`=0 carrying segment 0.
- From a `start` pulse at cycle t: `eng_rst` is 1 through t+RST_CYC. At t+RST_CYC+1, `eng_rst`=0, `eng_si`=seg[0], `frame_start`=1, `running`=1.
- From a `stop` pulse at cycle t: `eng_rst`=1, `eng_si`=0, `running`=0 at t+1.
- Load throughput is 1 beat/cycle. `ld_ready` depends on state only, never on `ld_valid`.

## Configuration
- `S4GA_CFG_PARITY_EN`, when defined:
  - Adds input `ld_par` (1 bit, even parity over `ld_data`) and sticky output `cfg_err`.
  - A beat with bad parity is still written and sets `cfg_err`.
  - `start` is ignored while `cfg_err`=1. `cfg_err` clears only on `rst`.
- When undefined: no `ld_par` or `cfg_err` ports, and no parity logic.

## Structure
- Package `s4ga_pkg`:
  - functions computing IDX_SEGS, MASK_SEGS, FRAME_SEGS, TOTAL_SEGS from N/K/SI_W, shared with the engine;
  - the state enum typedef (IDLE/RESET/RUN).
- Sub-module `s4ga_seg_ram`: single-port synchronous RAM, TOTAL_SEGS x SI_W, write-enable plus registered read. Single port suffices because load and run are mutually exclusive.

## Test plan
All scenarios use N=5, K=2, SI_W=4, giving FRAME_SEGS=3, TOTAL_SEGS=15, RST_CYC=7.
- **Load:** load beats 0x0..0xE -> `loaded` rises the cycle after the 15th beat, and `wptr` returns to 0.
- **Start:** `start` at t -> `eng_rst`=1 at t+1..t+7. At t+8: `eng_rst`=0, `eng_si`=0x0, `frame_start`=1. Then 0x1..0xE, then 0x0 with `frame_start`=1 at t+23.
- **Start before load complete:** `start` after 10 beats -> no state change, `eng_rst` stays 1.
- **Start/stop collision:** `stop` and `start` asserted together in RUN -> IDLE next cycle, `eng_si`=0, `ld_ready`=1.
- **Async reset:** `rst` asserted mid-RUN between clock edges -> outputs take reset values immediately. After release, `start` is ignored until a full reload.
- **Parity (with `S4GA_CFG_PARITY_EN`):** beat 0x3 with `ld_par`=1 -> `cfg_err`=1, and a later `start` is ignored.
